// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - Avalon-MM initiator/responder bus bundle
interface mem_bus_master_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - load/store to single Avalon-MM transactions
// Optional MEM_BUS_TIMEOUT_EN aborts a transfer after TIMEOUT_CYCLES stalls.
module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               ready,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    mem_bus_master_if.master   bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        accept;
    logic        bad_req;
    logic        in_bus;
    logic        bus_done;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wd_calc;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign in_bus   = (state == RD) || (state == WR);
    assign bus_done = in_bus && !bus.waitrequest;
    assign accept   = ready && (req_read || req_write);
    assign bad_req  = (req_read && req_write) || (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] stall_cnt;

    // Counter sits at zero while idle, so it is clear on entry to RD/WR.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            stall_cnt <= '0;
        end else if (in_bus && bus.waitrequest) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign timeout_hit = in_bus && bus.waitrequest && (stall_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        be_calc = 4'b1111;
        wd_calc = req_wdata;
        case (req_size)
            2'b00: begin
                be_calc = 4'b0001 << req_addr[1:0];
                wd_calc = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_calc = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane     = bus.readdata >> {lane_q, 3'b000};
        load_ext = bus.readdata;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = (state == IDLE) && !reset;
        resp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_req)       state_next = RESP;
                    else if (req_read) state_next = RD;
                    else               state_next = WR;
                end
            end
            RD, WR:  if (bus_done || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.address    <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.byteenable <= '0;
            bus.writedata  <= '0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            lane_q         <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lane_q     <= req_addr[1:0];
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        resp_err   <= bad_req;
                        resp_rdata <= '0;
                        if (!bad_req) begin
                            bus.address    <= {req_addr[31:2], 2'b00};
                            bus.read       <= req_read;
                            bus.write      <= req_write;
                            bus.byteenable <= be_calc;
                            bus.writedata  <= wd_calc;
                        end
                    end
                end
                RD, WR: begin
                    if (bus_done) begin
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        if (state == RD) resp_rdata <= load_ext;
                    end else if (timeout_hit) begin
                        bus.read   <= 1'b0;
                        bus.write  <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                default: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - directed bench for mem_bus_master
module tb_mem_bus_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    int          vectors = 0;
    int          miscompares = 0;

    mem_bus_master_if bus_if ();

`ifdef MEM_BUS_TIMEOUT_EN
    mem_bus_master #(.TIMEOUT_CYCLES(4)) dut (
`else
    mem_bus_master dut (
`endif
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .ready(ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_if.waitrequest = 1'b0;
        bus_if.readdata    = '0;
        tick(); tick();
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %0b want 0", ready); end
        vectors++; if ({bus_if.read, bus_if.write} !== 2'b00) begin miscompares++; $display("FAIL rst_strobes got %b want 00", {bus_if.read, bus_if.write}); end
        vectors++; if (bus_if.byteenable !== 4'h0 || bus_if.address !== 32'h0 || bus_if.writedata !== 32'h0) begin miscompares++; $display("FAIL rst_bus got be=%h addr=%h wd=%h want 0", bus_if.byteenable, bus_if.address, bus_if.writedata); end
        vectors++; if ({resp_valid, resp_err} !== 2'b00 || resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_resp got v=%b e=%b d=%h want 0", resp_valid, resp_err, resp_rdata); end
        reset = 1'b0;
        #1;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after got %0b want 1", ready); end
    endtask

    task automatic test_word_load();
        req_read = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'hBFC0_0004;
        bus_if.waitrequest = 1'b0; bus_if.readdata = 32'hDEAD_BEEF;
        tick();
        req_read = 1'b0;
        vectors++; if (bus_if.read !== 1'b1 || bus_if.write !== 1'b0) begin miscompares++; $display("FAIL wl_strobe got r=%b w=%b want r=1 w=0", bus_if.read, bus_if.write); end
        vectors++; if (bus_if.address !== 32'hBFC0_0004) begin miscompares++; $display("FAIL wl_addr got %h want bfc00004", bus_if.address); end
        vectors++; if (bus_if.byteenable !== 4'b1111) begin miscompares++; $display("FAIL wl_be got %b want 1111", bus_if.byteenable); end
        vectors++; if (ready !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL wl_busy got rdy=%b v=%b want 0 0", ready, resp_valid); end
        tick();
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin miscompares++; $display("FAIL wl_resp got v=%b e=%b want 1 0", resp_valid, resp_err); end
        vectors++; if (resp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wl_data got %h want deadbeef", resp_rdata); end
        vectors++; if (bus_if.read !== 1'b0) begin miscompares++; $display("FAIL wl_drop got %b want 0", bus_if.read); end
        tick();
        vectors++; if (resp_valid !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL wl_idle got v=%b rdy=%b want 0 1", resp_valid, ready); end
    endtask

    task automatic test_byte_load(input logic sgn, input logic [31:0] expect_d);
        req_read = 1'b1; req_size = 2'b00; req_signed = sgn; req_addr = 32'hBFC0_0003;
        bus_if.waitrequest = 1'b0; bus_if.readdata = 32'h8011_2233;
        tick();
        req_read = 1'b0;
        vectors++; if (bus_if.byteenable !== 4'b1000 || bus_if.address !== 32'hBFC0_0000) begin miscompares++; $display("FAIL bl_bus got be=%b addr=%h want 1000 bfc00000", bus_if.byteenable, bus_if.address); end
        tick();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== expect_d) begin miscompares++; $display("FAIL bl_data s=%0b got v=%b d=%h want 1 %h", sgn, resp_valid, resp_rdata, expect_d); end
        tick();
    endtask

    task automatic test_half_store();
        req_write = 1'b1; req_size = 2'b01; req_addr = 32'hBFC0_0002; req_wdata = 32'h0000_ABCD;
        bus_if.waitrequest = 1'b1;
        tick();
        req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.waitrequest = (i < 3);
            vectors++;
            if (bus_if.write !== 1'b1 || bus_if.read !== 1'b0 || bus_if.byteenable !== 4'b1100 ||
                bus_if.writedata !== 32'hABCD_ABCD || bus_if.address !== 32'hBFC0_0000 || resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hs_hold cyc%0d got w=%b r=%b be=%b wd=%h a=%h v=%b want 1 0 1100 abcdabcd bfc00000 0",
                         i, bus_if.write, bus_if.read, bus_if.byteenable, bus_if.writedata, bus_if.address, resp_valid);
            end
            tick();
        end
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || bus_if.write !== 1'b0) begin miscompares++; $display("FAIL hs_resp got v=%b e=%b d=%h w=%b want 1 0 0 0", resp_valid, resp_err, resp_rdata, bus_if.write); end
        tick();
    endtask

    task automatic test_byte_store();
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h0000_0401; req_wdata = 32'h1234_56A5;
        bus_if.waitrequest = 1'b0;
        tick();
        req_write = 1'b0;
        vectors++; if (bus_if.byteenable !== 4'b0010 || bus_if.writedata !== 32'hA5A5_A5A5 || bus_if.address !== 32'h0000_0400) begin miscompares++; $display("FAIL bs_bus got be=%b wd=%h a=%h want 0010 a5a5a5a5 00000400", bus_if.byteenable, bus_if.writedata, bus_if.address); end
        tick();
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin miscompares++; $display("FAIL bs_resp got v=%b e=%b want 1 0", resp_valid, resp_err); end
        tick();
    endtask

    task automatic test_errors();
        logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] addrs [4] = '{32'hBFC0_0001, 32'hBFC0_0003, 32'hBFC0_0000, 32'hBFC0_0000};
        logic        both  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            req_read = 1'b1; req_write = both[i]; req_size = sizes[i]; req_addr = addrs[i];
            bus_if.readdata = 32'hFFFF_FFFF;
            tick();
            req_read = 1'b0; req_write = 1'b0;
            vectors++;
            if (bus_if.read !== 1'b0 || bus_if.write !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL err_case%0d got r=%b w=%b v=%b e=%b d=%h want 0 0 1 1 0", i, bus_if.read, bus_if.write, resp_valid, resp_err, resp_rdata);
            end
            tick();
            vectors++; if (ready !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL err_idle%0d got rdy=%b v=%b want 1 0", i, ready, resp_valid); end
        end
    endtask

    task automatic test_reset_mid_read();
        int seen = 0;
        req_read = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0010;
        bus_if.waitrequest = 1'b1;
        tick();
        req_read = 1'b0;
        vectors++; if (bus_if.read !== 1'b1) begin miscompares++; $display("FAIL rm_read got %b want 1", bus_if.read); end
        reset = 1'b1;
        tick();
        vectors++; if (bus_if.read !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_drop got r=%b v=%b want 0 0", bus_if.read, resp_valid); end
        reset = 1'b0; bus_if.waitrequest = 1'b0;
        #1;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready got %b want 1", ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid !== 1'b0 || bus_if.read !== 1'b0) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL rm_quiet got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        req_read = 1'b1; req_size = 2'b01; req_signed = 1'b1; req_addr = 32'h0000_0102;
        bus_if.waitrequest = 1'b0; bus_if.readdata = 32'h8ACE_1234;
        tick();
        vectors++; if (bus_if.read !== 1'b1 || bus_if.byteenable !== 4'b1100) begin miscompares++; $display("FAIL bb_rd1 got r=%b be=%b want 1 1100", bus_if.read, bus_if.byteenable); end
        tick();
        bus_if.readdata = 32'hF00D_5678;
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_8ACE) begin miscompares++; $display("FAIL bb_resp1 got v=%b d=%h want 1 ffff8ace", resp_valid, resp_rdata); end
        tick();
        vectors++; if (ready !== 1'b1 || resp_valid !== 1'b0 || bus_if.read !== 1'b0) begin miscompares++; $display("FAIL bb_gap got rdy=%b v=%b r=%b want 1 0 0", ready, resp_valid, bus_if.read); end
        tick();
        vectors++; if (bus_if.read !== 1'b1) begin miscompares++; $display("FAIL bb_rd2 got %b want 1", bus_if.read); end
        req_read = 1'b0;
        tick();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_F00D) begin miscompares++; $display("FAIL bb_resp2 got v=%b d=%h want 1 fffff00d", resp_valid, resp_rdata); end
        tick();
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        req_read = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0020;
        bus_if.waitrequest = 1'b1;
        tick();
        req_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus_if.read !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL to_hold cyc%0d got r=%b v=%b want 1 0", i, bus_if.read, resp_valid); end
            tick();
        end
        vectors++; if (bus_if.read !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin miscompares++; $display("FAIL to_abort got r=%b v=%b e=%b d=%h want 0 1 1 0", bus_if.read, resp_valid, resp_err, resp_rdata); end
        bus_if.waitrequest = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_word_load();
        test_byte_load(1'b1, 32'hFFFF_FF80);
        test_byte_load(1'b0, 32'h0000_0080);
        test_half_store();
        test_byte_store();
        test_errors();
        test_reset_mid_read();
        test_back_to_back();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
